// File: rtl/cheri_pkg.sv
// Shared types for the CHERI data-memory responder: response pipeline entry,
// error-cause encoding and the request classifier.
package cheri_pkg;

    localparam int unsigned CapWidth = 33;
    localparam int unsigned TagBit   = 32;

    typedef enum logic [2:0] {
        ErrNone,
        ErrRange,
        ErrAlign,
        ErrCapBe,
        ErrIntg
    } err_cause_e;

    typedef struct packed {
        logic                valid;
        logic                we;
        logic                err;
        logic                cap;
        logic [CapWidth-1:0] rdata;
    } resp_entry_t;

    function automatic err_cause_e classify(
        input logic       in_range,
        input logic [1:0] addr_lsb,
        input logic       is_cap,
        input logic [3:0] be,
        input logic       we,
        input logic       intg_ok
    );
        if (!in_range)            return ErrRange;
        if (addr_lsb != 2'b00)    return ErrAlign;
        if (is_cap && be != 4'hF) return ErrCapBe;
        if (we && !intg_ok)       return ErrIntg;
        return ErrNone;
    endfunction

endpackage

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted Hsiao SECDED (39,32) encoder: data passes through in [31:0],
// check bits land in [38:32] and are inverted by 7'h2A.
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);
    always_comb begin
        data_o         = {7'h00, data_i};
        data_o[32]     = ^(data_i & 32'h2606_BD25);
        data_o[33]     = ^(data_i & 32'hDEBA_8050);
        data_o[34]     = ^(data_i & 32'h413D_89AA);
        data_o[35]     = ^(data_i & 32'h3123_4ED1);
        data_o[36]     = ^(data_i & 32'hC2C1_323B);
        data_o[37]     = ^(data_i & 32'h2DCC_624C);
        data_o[38]     = ^(data_i & 32'h9850_5586);
        data_o[38:32]  = data_o[38:32] ^ 7'h2A;
    end
endmodule

// File: rtl/cheri_dmem_responder.sv
// Data-memory responder for a CHERI core: validates each granted request, drives a
// tagged SRAM and returns fixed-latency, in-order responses with integrity bits.
module cheri_dmem_responder
    import cheri_pkg::*;
#(
    parameter int unsigned DataWidth   = 33,
    parameter logic [31:0] MemBase     = 32'h8000_0000,
    parameter int unsigned MemWords    = 4096,
    parameter int unsigned RespLatency = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        data_req_i,
    input  logic                        data_is_cap_i,
    input  logic                        data_we_i,
    input  logic [3:0]                  data_be_i,
    input  logic [31:0]                 data_addr_i,
    input  logic [DataWidth-1:0]        data_wdata_i,
    input  logic [6:0]                  data_wdata_intg_i,
    output logic                        data_gnt_o,
    output logic                        data_rvalid_o,
    output logic [DataWidth-1:0]        data_rdata_o,
    output logic [6:0]                  data_rdata_intg_o,
    output logic                        data_err_o,
    input  logic                        stall_i,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [$clog2(MemWords)-1:0] mem_addr_o,
    output logic [4:0]                  mem_be_o,
    output logic [DataWidth-1:0]        mem_wdata_o,
    input  logic [DataWidth-1:0]        mem_rdata_i,
    output logic [15:0]                 err_cnt_o
);
    localparam int unsigned AddrWidth = $clog2(MemWords);
    localparam logic [32:0] MemSpan   = 33'(MemWords) * 33'd4;

    logic [31:0]  offset;
    logic         in_range;
    logic         intg_ok;
    logic         good;
    logic [38:0]  wcode;
    logic [38:0]  rcode;
    err_cause_e   cause;
    resp_entry_t  entry;
    resp_entry_t  head;
    resp_entry_t  tail;
    resp_entry_t  pipe [RespLatency];

    prim_secded_inv_39_32_enc u_wdata_enc (
        .data_i (data_wdata_i[31:0]),
        .data_o (wcode)
    );

    prim_secded_inv_39_32_enc u_rdata_enc (
        .data_i (tail.rdata[31:0]),
        .data_o (rcode)
    );

    always_comb begin
        offset     = data_addr_i - MemBase;
        in_range   = (data_addr_i >= MemBase) && ({1'b0, offset} < MemSpan);
        intg_ok    = (wcode == {data_wdata_intg_i, data_wdata_i[31:0]});
        cause      = classify(in_range, data_addr_i[1:0], data_is_cap_i, data_be_i,
                              data_we_i, intg_ok);
        data_gnt_o = data_req_i & ~stall_i & ~rst_i;
        good       = data_gnt_o && (cause == ErrNone);
    end

    always_comb begin
        mem_req_o           = good;
        mem_we_o            = data_we_i;
        mem_addr_o          = offset[AddrWidth+1:2];
        mem_be_o            = data_we_i ? {1'b1, data_be_i} : '0;
        mem_wdata_o         = data_wdata_i;
        mem_wdata_o[TagBit] = data_wdata_i[TagBit] & data_is_cap_i;
    end

    always_comb begin
        entry       = '0;
        entry.valid = data_gnt_o;
        entry.we    = data_we_i;
        entry.err   = (cause != ErrNone);
        entry.cap   = data_is_cap_i;
    end

    // SRAM data arrives while the entry sits in stage 0, so it is merged there
    // before moving on; with a one-cycle latency this merged view is the output.
    always_comb begin
        head = pipe[0];
        if (pipe[0].valid && !pipe[0].we && !pipe[0].err) begin
            head.rdata = {mem_rdata_i[TagBit] & pipe[0].cap, mem_rdata_i[TagBit-1:0]};
        end
    end

    assign tail = (RespLatency == 1) ? head : pipe[RespLatency-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < RespLatency; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= entry;
            for (int unsigned i = 1; i < RespLatency; i++) begin
                pipe[i] <= (i == 1) ? head : pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (tail.valid && tail.err && (err_cnt_o != 16'hFFFF)) begin
            err_cnt_o <= err_cnt_o + 16'd1;
        end
    end

    always_comb begin
        data_rvalid_o     = tail.valid;
        data_err_o        = tail.valid & tail.err;
        data_rdata_o      = '0;
        data_rdata_intg_o = '0;
        if (tail.valid) begin
            data_rdata_o      = DataWidth'({tail.rdata[TagBit], rcode[31:0]});
            data_rdata_intg_o = rcode[38:32];
        end
    end

endmodule

// File: tb/tb_cheri_dmem_responder.sv
// Directed bench for cheri_dmem_responder: tagged SRAM model, expected-response
// queue with hand-computed data, latency and ordering checks.
module tb_cheri_dmem_responder;

    localparam int unsigned Lat   = 3;
    localparam int unsigned Words = 64;
    localparam logic [31:0] Base  = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        data_req_i;
    logic        data_is_cap_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [32:0] data_wdata_i;
    logic [6:0]  data_wdata_intg_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [32:0] data_rdata_o;
    logic [6:0]  data_rdata_intg_o;
    logic        data_err_o;
    logic        stall_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [5:0]  mem_addr_o;
    logic [4:0]  mem_be_o;
    logic [32:0] mem_wdata_o;
    logic [32:0] mem_rdata_i;
    logic [15:0] err_cnt_o;

    always #5 clk_i = ~clk_i;

    cheri_dmem_responder #(
        .DataWidth   (33),
        .MemBase     (Base),
        .MemWords    (Words),
        .RespLatency (Lat)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .data_req_i        (data_req_i),
        .data_is_cap_i     (data_is_cap_i),
        .data_we_i         (data_we_i),
        .data_be_i         (data_be_i),
        .data_addr_i       (data_addr_i),
        .data_wdata_i      (data_wdata_i),
        .data_wdata_intg_i (data_wdata_intg_i),
        .data_gnt_o        (data_gnt_o),
        .data_rvalid_o     (data_rvalid_o),
        .data_rdata_o      (data_rdata_o),
        .data_rdata_intg_o (data_rdata_intg_o),
        .data_err_o        (data_err_o),
        .stall_i           (stall_i),
        .mem_req_o         (mem_req_o),
        .mem_we_o          (mem_we_o),
        .mem_addr_o        (mem_addr_o),
        .mem_be_o          (mem_be_o),
        .mem_wdata_o       (mem_wdata_o),
        .mem_rdata_i       (mem_rdata_i),
        .err_cnt_o         (err_cnt_o)
    );

    // Tagged SRAM model: read data is valid the cycle after mem_req_o.
    logic [32:0] sram [Words];
    logic [32:0] sram_q;
    assign mem_rdata_i = sram_q;

    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
                end
                if (mem_be_o[4]) sram[mem_addr_o][32] <= mem_wdata_o[32];
            end else begin
                sram_q <= sram[mem_addr_o];
            end
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] enc7(input logic [31:0] d);
        logic [31:0] masks [7];
        logic [6:0]  p;
        masks = '{32'h2606_BD25, 32'hDEBA_8050, 32'h413D_89AA, 32'h3123_4ED1,
                  32'hC2C1_323B, 32'h2DCC_624C, 32'h9850_5586};
        for (int i = 0; i < 7; i++) p[i] = ^(d & masks[i]);
        return p ^ 7'h2A;
    endfunction

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [32:0] rdata;
    } exp_t;
    exp_t expq [$];

    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (data_rvalid_o) begin
                if (expq.size() == 0) begin
                    check_val("spurious_rvalid", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check_val("resp_latency", 64'(cyc - e.cyc), 64'(Lat));
                    check_val("resp_err", data_err_o, e.err);
                    check_val("resp_rdata", data_rdata_o, e.rdata);
                    check_val("resp_intg", data_rdata_intg_o, enc7(e.rdata[31:0]));
                end
            end else begin
                check_val("idle_outputs", {data_err_o, data_rdata_o, data_rdata_intg_o}, 64'd0);
            end
        end
    end

    // Entered just after a rising edge; holds stall for nstall cycles, then expects gnt.
    task automatic issue(input logic [31:0] addr, input logic we, input logic cap,
                         input logic [3:0] be, input logic [32:0] wdata, input logic bad_intg,
                         input int unsigned nstall, input logic exp_err,
                         input logic [32:0] exp_rdata);
        data_req_i        = 1'b1;
        data_addr_i       = addr;
        data_we_i         = we;
        data_is_cap_i     = cap;
        data_be_i         = be;
        data_wdata_i      = wdata;
        data_wdata_intg_i = enc7(wdata[31:0]) ^ {6'd0, bad_intg};
        for (int unsigned k = 0; k <= nstall; k++) begin
            stall_i = (k < nstall);
            #1;
            check_val("gnt", data_gnt_o, !stall_i);
            if (data_gnt_o) begin
                check_val("mem_req", mem_req_o, !exp_err);
                expq.push_back('{cyc, exp_err, exp_rdata});
            end
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic idle();
        data_req_i = 1'b0;
        stall_i    = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        data_req_i = 1'b0;
        stall_i    = 1'b0;
        for (int i = 0; i < 12 && expq.size() > 0; i++) begin
            @(posedge clk_i);
            #1;
        end
        check_val("drain", 64'(expq.size()), 64'd0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst_i             = 1'b1;
        data_req_i        = 1'b1;
        stall_i           = 1'b0;
        data_is_cap_i     = 1'b0;
        data_we_i         = 1'b0;
        data_be_i         = 4'hF;
        data_addr_i       = Base;
        data_wdata_i      = '0;
        data_wdata_intg_i = '0;
        #2;
        check_val("rst_gnt", data_gnt_o, 64'd0);
        check_val("rst_outputs",
                  {data_rvalid_o, data_err_o, data_rdata_o, data_rdata_intg_o, mem_req_o}, 64'd0);
        check_val("rst_err_cnt", err_cnt_o, 64'd0);
        data_req_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Tagged write/read round trip, then tag cleared by a non-capability write.
        issue(Base + 32'd4, 1'b1, 1'b1, 4'hF, 33'h1_DEADBEEF, 1'b0, 0, 1'b0, 33'h0);
        issue(Base + 32'd4, 1'b0, 1'b1, 4'hF, 33'h0,          1'b0, 0, 1'b0, 33'h1_DEADBEEF);
        issue(Base + 32'd8, 1'b1, 1'b0, 4'hF, 33'h1_DEADBEEF, 1'b0, 0, 1'b0, 33'h0);
        issue(Base + 32'd8, 1'b0, 1'b1, 4'hF, 33'h0,          1'b0, 0, 1'b0, 33'h0_DEADBEEF);
        issue(Base + 32'd4, 1'b0, 1'b0, 4'hF, 33'h0,          1'b0, 0, 1'b0, 33'h0_DEADBEEF);
        // Last word with a partial byte-enable overwrite.
        issue(Base + 32'hFC, 1'b1, 1'b0, 4'hF, 33'h0_AAAAAAAA, 1'b0, 0, 1'b0, 33'h0);
        issue(Base + 32'hFC, 1'b1, 1'b0, 4'h3, 33'h0_12345678, 1'b0, 0, 1'b0, 33'h0);
        issue(Base + 32'hFC, 1'b0, 1'b0, 4'hF, 33'h0,          1'b0, 0, 1'b0, 33'h0_AAAA5678);
        drain();
        check_val("err_cnt_none", err_cnt_o, 64'd0);

        issue(Base + 32'h100, 1'b0, 1'b0, 4'hF, 33'h0, 1'b0, 0, 1'b1, 33'h0);
        drain();
        check_val("err_cnt_range", err_cnt_o, 64'd1);

        issue(32'h7FFF_FFFC,  1'b0, 1'b0, 4'hF, 33'h0, 1'b0, 0, 1'b1, 33'h0);
        issue(Base + 32'd6,   1'b0, 1'b0, 4'hF, 33'h0, 1'b0, 0, 1'b1, 33'h0);
        issue(Base + 32'd4,   1'b0, 1'b1, 4'h3, 33'h0, 1'b0, 0, 1'b1, 33'h0);
        drain();
        check_val("err_cnt_misc", err_cnt_o, 64'd4);

        // Four reads with stalls interleaved between grants.
        issue(Base + 32'd4,  1'b0, 1'b1, 4'hF, 33'h0, 1'b0, 0, 1'b0, 33'h1_DEADBEEF);
        issue(Base + 32'd8,  1'b0, 1'b1, 4'hF, 33'h0, 1'b0, 0, 1'b0, 33'h0_DEADBEEF);
        issue(Base + 32'hFC, 1'b0, 1'b0, 4'hF, 33'h0, 1'b0, 1, 1'b0, 33'h0_AAAA5678);
        issue(Base + 32'd4,  1'b0, 1'b0, 4'hF, 33'h0, 1'b0, 2, 1'b0, 33'h0_DEADBEEF);
        drain();

        // Corrupted write integrity must leave the SRAM word untouched.
        issue(Base + 32'd4, 1'b1, 1'b1, 4'hF, 33'h0_12345678, 1'b1, 0, 1'b1, 33'h0);
        issue(Base + 32'd4, 1'b0, 1'b1, 4'hF, 33'h0,          1'b0, 0, 1'b0, 33'h1_DEADBEEF);
        drain();
        check_val("err_cnt_intg", err_cnt_o, 64'd5);

        // Reset with two reads in flight discards both.
        issue(Base + 32'd4, 1'b0, 1'b1, 4'hF, 33'h0, 1'b0, 0, 1'b0, 33'h1_DEADBEEF);
        issue(Base + 32'd8, 1'b0, 1'b1, 4'hF, 33'h0, 1'b0, 0, 1'b0, 33'h0_DEADBEEF);
        rst_i = 1'b1;
        expq.delete();
        #1;
        check_val("midrst_gnt", data_gnt_o, 64'd0);
        check_val("midrst_outputs",
                  {data_rvalid_o, data_err_o, data_rdata_o, data_rdata_intg_o, mem_req_o}, 64'd0);
        check_val("midrst_err_cnt", err_cnt_o, 64'd0);
        data_req_i = 1'b0;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        repeat (8) idle();
        check_val("post_rst_err_cnt", err_cnt_o, 64'd0);
        check_val("post_rst_queue", 64'(expq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
